// File: rtl/alu_pkg.sv
// Shared constants, operand-pair ROM and FSM state type for the ALU BIST controller.
package alu_pkg;

  localparam int W   = 6;
  localparam int OPW = 4;

  localparam logic [W-1:0] POLY = 6'b000011;

  localparam logic [OPW-1:0] OP_0 = 4'h0;
  localparam logic [OPW-1:0] OP_1 = 4'h1;
  localparam logic [OPW-1:0] OP_2 = 4'h2;
  localparam logic [OPW-1:0] OP_3 = 4'h3;
  localparam logic [OPW-1:0] OP_4 = 4'h4;
  localparam logic [OPW-1:0] OP_5 = 4'h5;
  localparam logic [OPW-1:0] OP_6 = 4'h6;
  localparam logic [OPW-1:0] OP_7 = 4'h7;
  localparam logic [OPW-1:0] OP_8 = 4'h8;
  localparam logic [OPW-1:0] OP_9 = 4'h9;
  localparam logic [OPW-1:0] OP_A = 4'hA;
  localparam logic [OPW-1:0] OP_B = 4'hB;
  localparam logic [OPW-1:0] OP_C = 4'hC;
  localparam logic [OPW-1:0] OP_D = 4'hD;
  localparam logic [OPW-1:0] OP_E = 4'hE;
  localparam logic [OPW-1:0] OP_F = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Operand pair ROM: pair0 = (13, 7), pair1 = (5, 12).
  function automatic logic [W-1:0] pair_a(input logic sel);
    logic [W-1:0] v;
    case (sel)
      1'b0:    v = 6'd13;
      1'b1:    v = 6'd5;
      default: v = 6'd0;
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] pair_b(input logic sel);
    logic [W-1:0] v;
    case (sel)
      1'b0:    v = 6'd7;
      1'b1:    v = 6'd12;
      default: v = 6'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_misr.sv
// W-bit multiple-input signature register with synchronous clear and enable.
module alu_misr #(
  parameter int           W    = 6,
  parameter logic [W-1:0] POLY = 6'b000011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  // Shift left, fold the MSB back through the taps, then absorb the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= {W{1'b0}};
    end else if (clr) begin
      sig <= {W{1'b0}};
    end else if (en) begin
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : {W{1'b0}}) ^ d;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST sequencer: sweeps 32 ALU vectors, streams each result and checks the MISR signature.
module alu_bist_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   exp_sig,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4:0]     out_idx,
  output logic [OPW-1:0] out_op,
  output logic [W-1:0]   out_y,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [W-1:0]   signature
);

  localparam logic [4:0] LAST_IDX = {1'b1, OP_F};

  state_t     state;
  logic [4:0] cnt;
  logic       misr_clr;
  logic       misr_en;

  assign misr_clr = (state == S_IDLE) && start;
  assign misr_en  = (state == S_SAMPLE);

  alu_misr #(.W(W), .POLY(POLY)) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (alu_y),
    .sig (signature)
  );

  // Sweep sequencer with registered ALU drive, record and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      alu_a     <= {W{1'b0}};
      alu_b     <= {W{1'b0}};
      alu_op    <= {OPW{1'b0}};
      out_valid <= 1'b0;
      out_idx   <= 5'd0;
      out_op    <= {OPW{1'b0}};
      out_y     <= {W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_DRIVE;
            cnt   <= 5'd0;
            pass  <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DRIVE: begin
          alu_a  <= pair_a(cnt[4]);
          alu_b  <= pair_b(cnt[4]);
          alu_op <= cnt[3:0];
          state  <= S_SAMPLE;
        end
        S_SAMPLE: begin
          // alu_y has had a full cycle to settle from the registered drive.
          out_y     <= alu_y;
          out_idx   <= cnt;
          out_op    <= alu_op;
          out_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              cnt   <= cnt + 5'd1;
              state <= S_DRIVE;
            end
          end else begin
            state <= S_EMIT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          pass  <= (signature == exp_sig);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
Built-in self-test sequencer and response collector for the 6-bit, 16-opcode combinational ALU.
- Drives the ALU operand/opcode inputs through a fixed vector set (2 operand pairs × 16 opcodes).
- Samples each ALU result, folds it into a 6-bit MISR signature and streams every (index, op, Y) record out over a valid/ready port.
- At the end, compares the signature against an expected value and reports pass/fail.

Parameters:
W, 6, operand/result width
OPW, 4, opcode width
POLY, 6'b000011, MISR feedback taps (x^6+x+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run the sweep; honoured only in IDLE
exp_sig  in  W  expected signature, sampled at the DONE compare
alu_a  out  W  registered operand A to ALU
alu_b  out  W  registered operand B to ALU
alu_op  out  OPW  registered opcode to ALU
alu_y  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
out_valid  out  1  result record valid
out_ready  in  1  downstream accepts record
out_idx  out  5  vector index 0..31 ({pair, op})
out_op  out  OPW  opcode of record
out_y  out  W  captured ALU result
busy  out  1  high from the cycle after start until DONE is exited
done  out  1  one-cycle pulse in DONE
pass  out  1  signature == exp_sig, held until the next accepted start
signature  out  W  current MISR value

Behaviour:
- Reset: state=IDLE; alu_a/alu_b/alu_op=0; out_valid=0; out_idx/out_op/out_y=0; busy=0; done=0; pass=0; signature=0; vector counter=0. Reset mid-sweep aborts immediately with the same values; no partial record is emitted.
- States: IDLE, DRIVE, SAMPLE, EMIT, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - Clears signature, counter and pass.
  - busy=1 from the next cycle.
- DRIVE: registers alu_a/alu_b from the pair ROM[counter[4]] and alu_op=counter[3:0]; -> SAMPLE.
- SAMPLE:
  - alu_y is stable (one full cycle after the registered drive); capture it into out_y.
  - Load out_idx=counter and out_op=alu_op; set out_valid=1.
  - MISR update: sig_next = {sig[4:0],1'b0} ^ (sig[5] ? POLY : 0) ^ alu_y.
  - -> EMIT.
- EMIT:
  - Hold out_valid and the record stable while out_ready=0; no timeout.
  - On out_valid&&out_ready: out_valid=0.
  - If counter==31 -> DONE; else counter+1 -> DRIVE.
- DONE: done=1 for one cycle; pass=(signature==exp_sig); busy=0 from the next cycle; -> IDLE.
- alu_a/alu_b/alu_op hold their last values outside DRIVE.
- start is ignored outside IDLE.
- start arriving on the DONE cycle is ignored; a start on the next cycle (IDLE) is accepted.
- Throughput: 3 cycles per vector with out_ready held high; 96 cycles + 1 DONE cycle per sweep, start to done.
- Counter wrap: 31 is terminal, so no wrap occurs.
- All arithmetic is modulo 2^W; no sign handling.

Decomposition:
- Shared package alu_pkg:
  - W, OPW
  - opcode constants OP_0..OP_F
  - operand pair ROM: pair0 = (13, 7), pair1 = (5, 12)
  - MISR POLY
  - state enum
- Sub-module: alu_misr (W-bit MISR with clear/enable). Small and reusable by other checkers.

Test Plan:
- Reset, then start with out_ready=1 -> first record has out_idx=0, op=0, alu_a=13, alu_b=7. Record 16 has alu_a=5, alu_b=12, op=0. done pulses exactly 97 cycles after start; 32 records total.
- alu_y forced to 0, exp_sig=0 -> signature stays 0, pass=1. Same run with exp_sig=6'h01 -> pass=0.
- Real ALU with bench reference model computing the expected MISR; exp_sig = model value -> pass=1. exp_sig = model^6'h01 -> pass=0.
- out_ready held low for 5 cycles during record 3 -> out_valid stays 1, and out_idx=3, out_op, out_y are unchanged across all 5 cycles. Exactly one transfer occurs after ready rises; total record count is still 32.
- start pulsed at records 10 and on the DONE cycle -> no restart and signature unaffected. start one cycle after DONE -> new sweep begins, pass cleared.
- rst asserted during record 20 -> the next cycle shows state IDLE, out_valid=0, busy=0, signature=0, alu_* = 0. A subsequent start runs a full 32-record sweep.
